// File: rtl/text_console.sv
// text_console: character-stream front end for the text-mode GPU.
// Accepts one byte per ch_valid/ch_ready handshake, keeps a cursor on the
// COLS x ROWS grid, and turns printable bytes into single text RAM writes.
// Line feeds, line wraps and form feeds blank RAM by sweeping BLANK writes.
module text_console #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ch_in,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [7:0]  data_out,
  output logic [11:0] write_address,
  output logic        w_en,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_CLEAR_LINE   = 2'd1,
    ST_CLEAR_SCREEN = 2'd2
  } state_e;

  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [11:0] LAST_COL_W = 12'(COLS - 1);
  localparam logic [11:0] LAST_ADDR  = 12'(COLS * ROWS - 1);

  // Control codes recognised by the console
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Row base address. For the standard 80-column grid the multiply is
  // replaced by two shifts and an add: y*80 = y*64 + y*16.
  function automatic logic [11:0] row_base(input logic [4:0] y);
    logic [11:0] y_w;
    y_w = {7'd0, y};
    if (COLS == 80) begin
      row_base = (y_w << 6) + (y_w << 4);
    end else begin
      row_base = y_w * 12'(COLS);
    end
  endfunction

  state_e      state_q;
  logic [6:0]  cursor_x_q;
  logic [4:0]  cursor_y_q;
  logic [7:0]  data_out_q;
  logic [11:0] write_address_q;
  logic        w_en_q;
  logic [11:0] clr_cnt_q;   // column index (line clear) or address (screen clear)
  logic [11:0] clr_base_q;  // base address of the row being line-cleared

  logic        accept_s;
  logic        printable_s;
  logic [4:0]  next_y_s;
  logic [11:0] cur_addr_s;
  logic [11:0] bs_addr_s;
  logic [11:0] next_base_s;

  // Handshake, byte classification and cursor-derived addresses
  always_comb begin
    accept_s    = ch_valid && (state_q == ST_IDLE);
    printable_s = (ch_in >= 8'h20) && (ch_in <= 8'h7E);
    if (cursor_y_q == LAST_ROW) begin
      next_y_s = 5'd0;
    end else begin
      next_y_s = cursor_y_q + 5'd1;
    end
    cur_addr_s  = row_base(cursor_y_q) + {5'd0, cursor_x_q};
    // Only used when cursor_x > 0, so it never steps into the previous row
    bs_addr_s   = cur_addr_s - 12'd1;
    next_base_s = row_base(next_y_s);
  end

  // Console FSM: cursor, clear sweeps and the registered RAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cursor_x_q      <= 7'd0;
      cursor_y_q      <= 5'd0;
      data_out_q      <= 8'h00;
      write_address_q <= 12'd0;
      w_en_q          <= 1'b0;
      clr_cnt_q       <= 12'd0;
      clr_base_q      <= 12'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // No write unless an accepted byte produces one below
          w_en_q <= 1'b0;
          if (accept_s) begin
            case (ch_in)
              CH_LF: begin
                cursor_x_q <= 7'd0;
                cursor_y_q <= next_y_s;
                clr_base_q <= next_base_s;
                clr_cnt_q  <= 12'd0;
                state_q    <= ST_CLEAR_LINE;
              end
              CH_CR: begin
                cursor_x_q <= 7'd0;
              end
              CH_BS: begin
                // Backspace never climbs to the previous row
                if (cursor_x_q != 7'd0) begin
                  cursor_x_q      <= cursor_x_q - 7'd1;
                  data_out_q      <= BLANK;
                  write_address_q <= bs_addr_s;
                  w_en_q          <= 1'b1;
                end else begin
                  cursor_x_q <= cursor_x_q;
                end
              end
              CH_FF: begin
                cursor_x_q <= 7'd0;
                cursor_y_q <= 5'd0;
                clr_cnt_q  <= 12'd0;
                state_q    <= ST_CLEAR_SCREEN;
              end
              default: begin
                if (printable_s) begin
                  data_out_q      <= ch_in;
                  write_address_q <= cur_addr_s;
                  w_en_q          <= 1'b1;
                  if (cursor_x_q == LAST_COL) begin
                    // Wrap: no scrolling, the next row (possibly row 0) is blanked
                    cursor_x_q <= 7'd0;
                    cursor_y_q <= next_y_s;
                    clr_base_q <= next_base_s;
                    clr_cnt_q  <= 12'd0;
                    state_q    <= ST_CLEAR_LINE;
                  end else begin
                    cursor_x_q <= cursor_x_q + 7'd1;
                  end
                end else begin
                  // Unsupported codes are consumed silently
                  cursor_x_q <= cursor_x_q;
                end
              end
            endcase
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_CLEAR_LINE: begin
          data_out_q      <= BLANK;
          write_address_q <= clr_base_q + clr_cnt_q;
          w_en_q          <= 1'b1;
          if (clr_cnt_q == LAST_COL_W) begin
            state_q <= ST_IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + 12'd1;
          end
        end

        ST_CLEAR_SCREEN: begin
          data_out_q      <= BLANK;
          write_address_q <= clr_cnt_q;
          w_en_q          <= 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + 12'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          w_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ch_ready      = (state_q == ST_IDLE);
  assign data_out      = data_out_q;
  assign write_address = write_address_q;
  assign w_en          = w_en_q;
  assign cursor_x      = cursor_x_q;
  assign cursor_y      = cursor_y_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: handshake, printable writes, control
// codes, line wrap at the last row, full-screen clear and reset mid-clear.
module tb_text_console;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ch_in;
  logic        ch_valid;
  logic        ch_ready;
  logic [7:0]  data_out;
  logic [11:0] write_address;
  logic        w_en;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int n_checks = 0;
  int n_errors = 0;

  text_console #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_in         (ch_in),
    .ch_valid      (ch_valid),
    .ch_ready      (ch_ready),
    .data_out      (data_out),
    .write_address (write_address),
    .w_en          (w_en),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a byte at a negedge; returns at the negedge of the cycle after acceptance
  task automatic send(input logic [7:0] b);
    chk_val("ready_at_send", {31'd0, ch_ready}, 32'd1);
    ch_in    = b;
    ch_valid = 1'b1;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_in    = 8'h00;
  endtask

  task automatic expect_write(input string tag, input int addr, input logic [7:0] d);
    chk_val({tag, "_wen"},  {31'd0, w_en}, 32'd1);
    chk_val({tag, "_addr"}, {20'd0, write_address}, addr);
    chk_val({tag, "_data"}, {24'd0, data_out}, {24'd0, d});
  endtask

  task automatic expect_cursor(input string tag, input int x, input int y);
    chk_val({tag, "_cx"}, {25'd0, cursor_x}, x);
    chk_val({tag, "_cy"}, {27'd0, cursor_y}, y);
  endtask

  // Entered at the negedge of cycle N+1 (ready already low there).
  // Expects blank writes to base..base+count-1 in N+2..N+count+1.
  task automatic check_clear(input string tag, input int base, input int count);
    int good;
    int low;
    good = 0;
    low  = (ch_ready === 1'b0) ? 1 : 0;
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      if (w_en === 1'b1 && write_address === 12'(base + k) && data_out === 8'h20) good++;
      if (ch_ready === 1'b0) low++;
    end
    chk_val({tag, "_writes"}, good, count);
    chk_val({tag, "_low_cycles"}, low, count);
    chk_val({tag, "_ready_back"}, {31'd0, ch_ready}, 32'd1);
    @(negedge clk);
    chk_val({tag, "_idle_wen"}, {31'd0, w_en}, 32'd0);
  endtask

  // LF (or similar) that produces no character write, then a row clear
  task automatic send_lf(input string tag, input int base);
    send(8'h0A);
    chk_val({tag, "_nowr"}, {31'd0, w_en}, 32'd0);
    chk_val({tag, "_busy"}, {31'd0, ch_ready}, 32'd0);
    check_clear(tag, base, 80);
  endtask

  initial begin
    int good;
    rst_n    = 1'b0;
    ch_valid = 1'b0;
    ch_in    = 8'h00;
    repeat (2) @(negedge clk);
    chk_val("rst_wen",   {31'd0, w_en}, 32'd0);
    chk_val("rst_addr",  {20'd0, write_address}, 32'd0);
    chk_val("rst_data",  {24'd0, data_out}, 32'd0);
    chk_val("rst_ready", {31'd0, ch_ready}, 32'd1);
    expect_cursor("rst", 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // "Hi" back to back
    ch_in = 8'h48; ch_valid = 1'b1;
    @(negedge clk);
    expect_write("hi_H", 0, 8'h48);
    chk_val("hi_ready1", {31'd0, ch_ready}, 32'd1);
    ch_in = 8'h69;
    @(negedge clk);
    expect_write("hi_i", 1, 8'h69);
    chk_val("hi_ready2", {31'd0, ch_ready}, 32'd1);
    ch_valid = 1'b0; ch_in = 8'h00;
    expect_cursor("hi", 2, 0);
    @(negedge clk);
    chk_val("hi_idle_wen", {31'd0, w_en}, 32'd0);

    // Unsupported codes and CR
    send(8'h7F);
    chk_val("del_nowr", {31'd0, w_en}, 32'd0);
    expect_cursor("del", 2, 0);
    send(8'h80);
    chk_val("hi80_nowr", {31'd0, w_en}, 32'd0);
    expect_cursor("hi80", 2, 0);
    send(8'h0D);
    chk_val("cr_nowr", {31'd0, w_en}, 32'd0);
    expect_cursor("cr", 0, 0);

    // Down to row 2, backspace at column 0
    send_lf("lf_r1", 80);
    send_lf("lf_r2", 160);
    expect_cursor("at_r2", 0, 2);
    send(8'h08);
    chk_val("bs0_nowr", {31'd0, w_en}, 32'd0);
    expect_cursor("bs0", 0, 2);

    // Backspace at column 7 of row 2
    for (int i = 0; i < 7; i++) send(8'h61);
    expect_cursor("pre_bs", 7, 2);
    send(8'h08);
    expect_write("bs7", 166, 8'h20);
    expect_cursor("bs7", 6, 2);

    // From (5,3) send LF: row 4 cleared
    send_lf("lf_r3", 240);
    for (int i = 0; i < 5; i++) send(8'h62);
    expect_cursor("pre_lf", 5, 3);
    send_lf("lf_r4", 320);
    expect_cursor("lf_r4", 0, 4);

    // Down to row 29 and fill it with 'A'
    for (int r = 5; r < 30; r++) send_lf("lf_walk", r * 80);
    expect_cursor("at_r29", 0, 29);
    good = 0;
    for (int i = 0; i < 79; i++) begin
      send(8'h41);
      if (w_en === 1'b1 && write_address === 12'(2320 + i) && data_out === 8'h41) good++;
    end
    chk_val("row29_fill", good, 79);
    send(8'h41);
    expect_write("last_A", 2399, 8'h41);
    chk_val("wrap_busy", {31'd0, ch_ready}, 32'd0);
    expect_cursor("wrap", 0, 0);
    check_clear("wrap_clr", 0, 80);

    // Walk to (10,10) then FF
    for (int r = 1; r <= 10; r++) send_lf("lf_ten", r * 80);
    for (int i = 0; i < 10; i++) send(8'h78);
    expect_cursor("pre_ff", 10, 10);
    send(8'h0C);
    chk_val("ff_nowr", {31'd0, w_en}, 32'd0);
    chk_val("ff_busy", {31'd0, ch_ready}, 32'd0);
    expect_cursor("ff", 0, 0);
    check_clear("ff_clr", 0, 2400);

    // Reset midway through an FF clear
    send(8'h51);
    send(8'h52);
    send(8'h0C);
    repeat (1000) @(negedge clk);
    chk_val("mid_ff_wen",   {31'd0, w_en}, 32'd1);
    chk_val("mid_ff_ready", {31'd0, ch_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_val("arst_wen",   {31'd0, w_en}, 32'd0);
    chk_val("arst_addr",  {20'd0, write_address}, 32'd0);
    chk_val("arst_data",  {24'd0, data_out}, 32'd0);
    chk_val("arst_ready", {31'd0, ch_ready}, 32'd1);
    expect_cursor("arst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_val("post_rst_ready", {31'd0, ch_ready}, 32'd1);
    chk_val("post_rst_wen",   {31'd0, w_en}, 32'd0);
    expect_cursor("post_rst", 0, 0);
    send(8'h5A);
    expect_write("Z", 0, 8'h5A);
    expect_cursor("Z", 1, 0);
    @(negedge clk);
    chk_val("final_idle_wen", {31'd0, w_en}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/text_console.md
# text_console

Character-stream front end for the text-mode GPU. Accepts one byte per valid/ready handshake from the CPU-side I/O port and maintains a cursor on the 80x30 character grid. Each printable byte becomes a single write into the GPU text RAM through the GPU's `data_in`/`write_address`/`w_en` write port. Control codes move the cursor, and line and screen clears are performed by sweeping blank characters into the RAM.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows per screen.
- `BLANK`, default 8'h20: byte written by clears and backspace.
- `clk` input 1: system clock; all logic is in this single domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ch_in` input 8: incoming character byte.
- `ch_valid` input 1: `ch_in` is valid.
- `ch_ready` output 1: console can accept a byte. Combinational: high exactly when the state is IDLE.
- `data_out` output 8: byte to text RAM. Registered; drives the GPU `data_in`.
- `write_address` output 12: text RAM address, equal to row*COLS+col. Registered.
- `w_en` output 1: one-cycle write strobe per RAM write. Registered.
- `cursor_x` output 7: current column, 0..COLS-1.
- `cursor_y` output 5: current row, 0..ROWS-1.

## Operation
- States:
  - IDLE: accepting bytes.
  - CLEAR_LINE: 80 writes of BLANK to one row.
  - CLEAR_SCREEN: 2400 writes of BLANK to the whole screen.
- A byte is accepted on any rising edge where `ch_valid && ch_ready`.
- Handling of an accepted byte:
  - 0x20–0x7E (printable): write the byte at (cursor_x, cursor_y), then increment cursor_x.
    - If cursor_x was COLS-1: cursor_x←0, cursor_y←next row, enter CLEAR_LINE for the new row.
  - 0x0A (LF): cursor_x←0, cursor_y←next row, enter CLEAR_LINE. No character write.
  - 0x0D (CR): cursor_x←0. No write.
  - 0x08 (BS):
    - If cursor_x>0: cursor_x←cursor_x-1 and write BLANK at the new position.
    - If cursor_x==0: no-op; the cursor never moves up a row.
  - 0x0C (FF): cursor←(0,0), enter CLEAR_SCREEN.
  - All other values, including 0x7F and ≥0x80: consumed, no write, cursor unchanged.
- Next row = cursor_y+1, wrapping ROWS-1→0. There is no scrolling: the display wraps to the top and the new row is blanked.
- Addressing:
  - Row base = cursor_y*80, computed as (y<<6)+(y<<4) in 12 bits.
  - Maximum address is 2399. `write_address` never exceeds COLS*ROWS-1.
- CLEAR_LINE writes columns 0..79 of the target row in ascending order, one per cycle.
- CLEAR_SCREEN writes addresses 0..2399 in ascending order, one per cycle.
- Reset, asserted at any time including mid-clear:
  - Immediately: `w_en`=0, `write_address`=0, `data_out`=0, cursor=(0,0), state IDLE, so `ch_ready`=1.
  - A partially cleared screen is left as is.

## Timing
- Byte accepted at edge ending cycle N. Printable or BS write: `w_en`=1 in cycle N+1 with its address and data. `ch_ready` stays high, so throughput is one byte per cycle.
- Line wrap (printable at column 79) or LF:
  - The character write, if any, appears in N+1.
  - Clear writes appear in N+2..N+81.
  - `ch_ready` is low in N+1..N+80 and high in N+81.
  - A byte accepted in N+81 writes in N+82, so write ordering is always preserved.
- FF: clear writes appear in N+2..N+2401. `ch_ready` is low in N+1..N+2400 and high in N+2401.
- `w_en` is low in every cycle without a write, including N+1 for LF/FF and all IDLE cycles without an accepted byte.
- `cursor_x`/`cursor_y` update at the acceptance edge and are valid in N+1.
- `ch_in` is ignored whenever `ch_ready` is low. Upstream must hold `ch_valid` and `ch_in` until accepted.

## Test plan
- After reset, send "Hi" on back-to-back cycles:
  - (addr 0, 0x48) and (addr 1, 0x69) on consecutive cycles.
  - cursor=(2,0).
  - `ch_ready` never drops.
- From cursor (5,3), send LF:
  - No char write.
  - 80 writes of 0x20 to addresses 320..399.
  - cursor=(0,4).
  - `ch_ready` low for exactly 80 cycles.
- Fill row 29 to column 79 with 'A':
  - Last 'A' is written at 2399.
  - Then addresses 0..79 are cleared.
  - cursor=(0,0).
- BS handling:
  - At cursor (0,2): BS produces no write; cursor stays (0,2).
  - At cursor (7,2): BS writes 0x20 at 166; cursor becomes (6,2).
- FF at cursor (10,10):
  - 2400 sequential blank writes to addresses 0..2399.
  - cursor=(0,0).
  - `ch_ready` returns high after 2400 low cycles.
- Assert `rst_n` low midway through an FF clear:
  - `w_en` drops immediately.
  - After release: `ch_ready`=1, cursor=(0,0).
  - Next byte 'Z' is written at address 0 one cycle after acceptance.
